// File: rtl/addsub_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM encoding and
// elaboration-time helpers for chunk count and chunk-index width.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices in a WIDTH-bit operand; guarded so an
    // illegal CHUNK still elaborates far enough to hit the parameter check.
    function automatic int num_chunks(input int width, input int chunk);
        return (chunk > 0) ? width / chunk : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple slice: sum and carry-out of a + b + cin.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

endmodule

// File: rtl/addsub_seq.sv
// Sequential adder/subtractor: processes CHUNK bits per cycle through a single
// add_chunk slice and publishes result plus ALU flags together on completion.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int IW = idx_width(N);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic [IW-1:0]    idx;
    logic             cin;
    logic             load, step, last;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             cout_chunk;
    int               shamt;

    assign last = (idx == IW'(N - 1));
    assign busy = (state == BUSY);
    assign done = (state == DONE);

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = start ? BUSY : IDLE;
                load       = start;
            end
            BUSY: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the active slice by shifting, then merge the new sum into the
    // partial accumulator (cleared on load, so OR-ing is sufficient).
    always_comb begin
        shamt    = int'(idx) * CHUNK;
        a_chunk  = CHUNK'(op_a >> shamt);
        b_chunk  = CHUNK'(op_b >> shamt);
        acc_next = acc | (WIDTH'(sum_chunk) << shamt);
    end

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (cin),
        .sum  (sum_chunk),
        .cout (cout_chunk)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            idx      <= '0;
            cin      <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (load) begin
            op_a <= a;
            op_b <= b ^ {WIDTH{sub}};
            cin  <= sub;
            idx  <= '0;
            acc  <= '0;
        end else if (step) begin
            acc <= acc_next;
            cin <= cout_chunk;
            idx <= last ? '0 : idx + 1'b1;
            if (last) begin
                result   <= acc_next;
                carry    <= cout_chunk;
                overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (acc_next[WIDTH-1] != op_a[WIDTH-1]);
                zero     <= (acc_next == '0);
                negative <= acc_next[WIDTH-1];
            end
        end
    end

endmodule
